// File: rtl/trigproc_if.sv
// Trigger processor port bundle: trigger/control inputs toward the block, link and counters back.
// trigin is a one-cycle pulse with no ready/backpressure; a pulse the block cannot take is counted in lostcnt.
interface trigproc_if;
  logic        trigin;
  logic        inhibit;
  logic [15:0] prescale;
  logic [15:0] tdata;
  logic        tcomma;
  logic [29:0] tnum;
  logic [15:0] lostcnt;
  logic [1:0]  state_dbg;

  modport master (
    output trigin, inhibit, prescale,
    input  tdata, tcomma, tnum, lostcnt, state_dbg
  );

  modport slave (
    input  trigin, inhibit, prescale,
    output tdata, tcomma, tnum, lostcnt, state_dbg
  );
endinterface

// File: rtl/trigproc.sv
// Trigger processor: inhibit, optional prescale (TRIGPROC_PRESCALE_EN), dead time, numbered
// two-word frames on a 16-bit comma/data link, saturating dropped-trigger counter.
module trigproc #(
  parameter int unsigned DEADTIME = 16
) (
  input  logic       clk,
  input  logic       reset,
  trigproc_if.slave  bus
);
  localparam logic [15:0] CH_COMMA = 16'h00BC;

  typedef enum logic [1:0] {IDLE, SEND0, SEND1, DEAD} state_t;

  state_t      state;
  logic [7:0]  dead_cnt;
  logic [29:0] tnum_q;
  logic [29:0] frame_q;
  logic [15:0] lost_q;
  logic [15:0] tdata_q;
  logic        tcomma_q;
  logic        eligible;
  logic        lost;
  logic        accept;

  assign eligible = bus.trigin && (state == IDLE) && !bus.inhibit;
  assign lost     = bus.trigin && ((state != IDLE) || bus.inhibit);

`ifdef TRIGPROC_PRESCALE_EN
  logic [15:0] pcnt;

  // >= rather than == so lowering prescale at run time never stalls acceptance.
  assign accept = eligible && (pcnt >= bus.prescale);

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= 16'd0;
    end else if (eligible) begin
      pcnt <= accept ? 16'd0 : pcnt + 16'd1;
    end
  end
`else
  logic unused_prescale;
  assign unused_prescale = ^bus.prescale;
  assign accept = eligible;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      dead_cnt <= 8'd0;
      tnum_q   <= 30'd0;
      frame_q  <= 30'd0;
      lost_q   <= 16'd0;
      tdata_q  <= CH_COMMA;
      tcomma_q <= 1'b1;
    end else begin
      if (lost && (lost_q != 16'hFFFF)) begin
        lost_q <= lost_q + 16'd1;
      end
      case (state)
        IDLE: begin
          tdata_q  <= CH_COMMA;
          tcomma_q <= 1'b1;
          if (accept) begin
            frame_q <= tnum_q;
            state   <= SEND0;
          end
        end
        SEND0: begin
          tdata_q  <= {1'b1, frame_q[29:15]};
          tcomma_q <= 1'b0;
          tnum_q   <= tnum_q + 30'd1;
          state    <= SEND1;
        end
        SEND1: begin
          tdata_q  <= {1'b0, frame_q[14:0]};
          tcomma_q <= 1'b0;
          dead_cnt <= 8'(DEADTIME - 1);
          state    <= DEAD;
        end
        DEAD: begin
          tdata_q  <= CH_COMMA;
          tcomma_q <= 1'b1;
          if (dead_cnt == 8'd0) begin
            state <= IDLE;
          end else begin
            dead_cnt <= dead_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tdata     = tdata_q;
  assign bus.tcomma    = tcomma_q;
  assign bus.tnum      = tnum_q;
  assign bus.lostcnt   = lost_q;
  assign bus.state_dbg = state;
endmodule
